// File: rtl/event_stretch.sv
// Event stretcher: turns single-cycle EV strobes into 2^DELAY-cycle high pulses, each followed
// by at least 2^DELAY low cycles. Optional retrigger via EVENT_STRETCH_RETRIGGER_EN.
module event_stretch #(
    parameter int unsigned DELAY  = 16,
    parameter int unsigned PEND_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EV,
    input  logic              OVF_clr,
    output logic              OUT_state,
    output logic              OUT_down,
    output logic              OUT_up,
    output logic              BUSY,
    output logic [PEND_W-1:0] PEND,
    output logic              OVF
);

    typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

    localparam logic [DELAY-1:0]  CntOne  = DELAY'(1);
    localparam logic [PEND_W-1:0] PendOne = PEND_W'(1);

    state_e            state_q, state_d;
    logic [DELAY-1:0]  cnt_q, cnt_d;
    logic              out_q, out_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;

    logic cnt_max;
    logic start;
    logic retrig;
    logic ev_queue;
    logic ovf_set;

    assign cnt_max = &cnt_q;

`ifdef EVENT_STRETCH_RETRIGGER_EN
    // An event during the high phase extends it instead of being queued.
    assign retrig = (state_q == StOn) & EV;
`else
    assign retrig = 1'b0;
`endif

    assign ev_queue = EV & ~retrig;
    assign start    = ((state_q == StIdle) | ((state_q == StOff) & cnt_max)) &
                      (EV | (|pend_q));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StOn;
                    out_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            StOn: begin
                cnt_d = cnt_q + CntOne;
                if (retrig) begin
                    cnt_d = '0;
                end else if (cnt_max) begin
                    state_d = StOff;
                    out_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            StOff: begin
                cnt_d = cnt_q + CntOne;
                if (cnt_max) begin
                    cnt_d = '0;
                    if (start) begin
                        state_d = StOn;
                        out_d   = 1'b1;
                    end else begin
                        state_d = StIdle;
                        out_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                out_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // Saturating queue: a new event with no concurrent start is dropped once full.
    always_comb begin
        pend_d  = pend_q;
        ovf_set = 1'b0;
        if (ev_queue && !start) begin
            if (&pend_q) begin
                ovf_set = 1'b1;
            end else begin
                pend_d = pend_q + PendOne;
            end
        end else if (!ev_queue && start) begin
            pend_d = pend_q - PendOne;
        end
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (OVF_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign OUT_state = out_q;
    assign OUT_down  = start;
    assign OUT_up    = (state_q == StOn) & cnt_max & ~retrig;
    assign BUSY      = (state_q != StIdle);
    assign PEND      = pend_q;
    assign OVF       = ovf_q;

endmodule

// File: tb/tb_event_stretch.sv
// Table-driven bench for event_stretch (DELAY=2, PEND_W=2) with a per-cycle expectation queue.
module tb_event_stretch;

    localparam int unsigned DELAY  = 2;
    localparam int unsigned PEND_W = 2;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              EV = 1'b0;
    logic              OVF_clr = 1'b0;
    logic              OUT_state, OUT_down, OUT_up, BUSY, OVF;
    logic [PEND_W-1:0] PEND;

    event_stretch #(
        .DELAY (DELAY),
        .PEND_W(PEND_W)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .EV       (EV),
        .OVF_clr  (OVF_clr),
        .OUT_state(OUT_state),
        .OUT_down (OUT_down),
        .OUT_up   (OUT_up),
        .BUSY     (BUSY),
        .PEND     (PEND),
        .OVF      (OVF)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       ev;
        logic       clr;
        logic       st;
        logic       dn;
        logic       up;
        logic       busy;
        logic [1:0] pend;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input int idx, input logic [6:0] act,
                         input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: {st,dn,up,busy,pend,ovf} got %b want %b", name, idx, act, exp);
        end
    endtask

    task automatic add(input int n, input logic ev, input logic clr, input logic st,
                       input logic dn, input logic up, input logic busy, input logic [1:0] pend,
                       input logic ovf);
        repeat (n) vecs.push_back('{ev, clr, st, dn, up, busy, pend, ovf});
    endtask

    task automatic idle(input int n);
        add(n, 0, 0, 0, 0, 0, 0, 2'd0, 0);
    endtask

    task automatic run_vecs(input string name);
        vec_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge CLK);
            #1;
            EV      = vecs[i].ev;
            OVF_clr = vecs[i].clr;
            sb.push_back(vecs[i]);
            @(negedge CLK);
            e = sb.pop_front();
            check(name, i, {OUT_state, OUT_down, OUT_up, BUSY, PEND, OVF},
                  {e.st, e.dn, e.up, e.busy, e.pend, e.ovf});
        end
        vecs.delete();
    endtask

    // Reset is asserted between edges; outputs must clear before the next edge.
    task automatic do_reset(input string name);
        @(posedge CLK);
        #2;
        EV      = 1'b0;
        OVF_clr = 1'b0;
        RST     = 1'b1;
        #1;
        check(name, 0, {OUT_state, OUT_down, OUT_up, BUSY, PEND, OVF}, 7'b0);
        @(posedge CLK);
        #1;
        check(name, 1, {OUT_state, OUT_down, OUT_up, BUSY, PEND, OVF}, 7'b0);
        RST = 1'b0;
    endtask

    task automatic load_single();
        idle(2);
        add(1, 1, 0, 0, 1, 0, 0, 2'd0, 0);
        add(3, 0, 0, 1, 0, 0, 1, 2'd0, 0);
        add(1, 0, 0, 1, 0, 1, 1, 2'd0, 0);
        add(4, 0, 0, 0, 0, 0, 1, 2'd0, 0);
        idle(2);
    endtask

    initial begin
        do_reset("reset_init");

        load_single();
        run_vecs("single");

        // Reset in the middle of a high phase, then a clean full pulse.
        idle(2);
        add(1, 1, 0, 0, 1, 0, 0, 2'd0, 0);
        add(2, 0, 0, 1, 0, 0, 1, 2'd0, 0);
        run_vecs("pre_reset");
        do_reset("reset_mid_on");
        load_single();
        run_vecs("after_reset");

`ifdef EVENT_STRETCH_RETRIGGER_EN
        idle(2);
        add(1, 1, 0, 0, 1, 0, 0, 2'd0, 0);
        add(2, 0, 0, 1, 0, 0, 1, 2'd0, 0);
        add(1, 1, 0, 1, 0, 0, 1, 2'd0, 0);
        add(3, 0, 0, 1, 0, 0, 1, 2'd0, 0);
        add(1, 0, 0, 1, 0, 1, 1, 2'd0, 0);
        add(4, 0, 0, 0, 0, 0, 1, 2'd0, 0);
        idle(2);
        run_vecs("retrigger");
`else
        // EVs at 10, 12, 13: three pulses rising at 11, 19, 27.
        idle(2);
        add(1, 1, 0, 0, 1, 0, 0, 2'd0, 0);
        add(1, 0, 0, 1, 0, 0, 1, 2'd0, 0);
        add(1, 1, 0, 1, 0, 0, 1, 2'd0, 0);
        add(1, 1, 0, 1, 0, 0, 1, 2'd1, 0);
        add(1, 0, 0, 1, 0, 1, 1, 2'd2, 0);
        add(3, 0, 0, 0, 0, 0, 1, 2'd2, 0);
        add(1, 0, 0, 0, 1, 0, 1, 2'd2, 0);
        add(3, 0, 0, 1, 0, 0, 1, 2'd1, 0);
        add(1, 0, 0, 1, 0, 1, 1, 2'd1, 0);
        add(3, 0, 0, 0, 0, 0, 1, 2'd1, 0);
        add(1, 0, 0, 0, 1, 0, 1, 2'd1, 0);
        add(3, 0, 0, 1, 0, 0, 1, 2'd0, 0);
        add(1, 0, 0, 1, 0, 1, 1, 2'd0, 0);
        add(4, 0, 0, 0, 0, 0, 1, 2'd0, 0);
        idle(2);
        run_vecs("queue3");

        // Saturation, OVF clear, and set-wins-over-clear.
        idle(2);
        add(1, 1, 0, 0, 1, 0, 0, 2'd0, 0);
        add(1, 1, 0, 1, 0, 0, 1, 2'd0, 0);
        add(1, 1, 0, 1, 0, 0, 1, 2'd1, 0);
        add(1, 1, 0, 1, 0, 0, 1, 2'd2, 0);
        add(1, 1, 0, 1, 0, 1, 1, 2'd3, 0);
        add(1, 0, 1, 0, 0, 0, 1, 2'd3, 1);
        add(1, 1, 1, 0, 0, 0, 1, 2'd3, 0);
        add(1, 0, 0, 0, 0, 0, 1, 2'd3, 1);
        add(1, 0, 0, 0, 1, 0, 1, 2'd3, 1);
        add(1, 0, 0, 1, 0, 0, 1, 2'd2, 1);
        run_vecs("overflow");
        do_reset("reset_ovf");

        // EV in the last OFF cycle with PEND=1: no IDLE gap, PEND held.
        idle(2);
        add(1, 1, 0, 0, 1, 0, 0, 2'd0, 0);
        add(1, 1, 0, 1, 0, 0, 1, 2'd0, 0);
        add(2, 0, 0, 1, 0, 0, 1, 2'd1, 0);
        add(1, 0, 0, 1, 0, 1, 1, 2'd1, 0);
        add(3, 0, 0, 0, 0, 0, 1, 2'd1, 0);
        add(1, 1, 0, 0, 1, 0, 1, 2'd1, 0);
        add(3, 0, 0, 1, 0, 0, 1, 2'd1, 0);
        add(1, 0, 0, 1, 0, 1, 1, 2'd1, 0);
        add(3, 0, 0, 0, 0, 0, 1, 2'd1, 0);
        add(1, 0, 0, 0, 1, 0, 1, 2'd1, 0);
        add(1, 0, 0, 1, 0, 0, 1, 2'd0, 0);
        run_vecs("coincident");
        do_reset("reset_end");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
